// File: rtl/mau_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mau_pkg
//  Description : Shared types and helpers for the memory access unit.
//                size_e   - request access size encoding
//                state_e  - control FSM states
//                aligned_ok() - natural-alignment check for a size/offset
//  Revision    : 1.0 - initial release
// ============================================================================
package mau_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RMW_RD = 3'd2,
      STORE  = 3'd3,
      RESP   = 3'd4,
      ERR    = 3'd5
   } state_e;

   // Reserved size is never aligned, so it folds into the same error path.
   function automatic logic aligned_ok(input size_e size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: aligned_ok = 1'b1;
         SZ_HALF: aligned_ok = ~addr_lo[0];
         SZ_WORD: aligned_ok = (addr_lo == 2'b00);
         default: aligned_ok = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mau_lane_mux.sv
`default_nettype none
// ============================================================================
//  Module      : mau_lane_mux
//  Description : Combinational byte-lane steering for the memory access unit.
//                Load path : extract byte/half/word from 'word' at 'addr_lo'
//                            and sign/zero-extend to 32 bits.
//                Store path: replace the addressed lane(s) of 'word' with the
//                            low bits of 'wdata' (word size: wdata as-is).
//  Ports       : word[31:0]  in  memory read word
//                addr_lo[1:0] in byte offset within the word (little-endian)
//                size        in  access size (size_e)
//                sgn         in  1 = sign-extend loads
//                wdata[31:0] in  right-justified store data
//                load_data   out extended load result
//                merge_data  out word with target lane(s) replaced
//  Revision    : 1.0 - initial release
// ============================================================================
module mau_lane_mux
   import mau_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  size_e       size,
   input  logic        sgn,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (addr_lo)
         2'd0:    w_byte = word[7:0];
         2'd1:    w_byte = word[15:8];
         2'd2:    w_byte = word[23:16];
         default: w_byte = word[31:24];
      endcase
      w_half = addr_lo[1] ? word[31:16] : word[15:0];

      case (size)
         SZ_BYTE: load_data = {{24{sgn & w_byte[7]}}, w_byte};
         SZ_HALF: load_data = {{16{sgn & w_half[15]}}, w_half};
         default: load_data = word;
      endcase

      merge_data = word;
      case (size)
         SZ_BYTE: begin
            case (addr_lo)
               2'd0:    merge_data[7:0]   = wdata[7:0];
               2'd1:    merge_data[15:8]  = wdata[7:0];
               2'd2:    merge_data[23:16] = wdata[7:0];
               default: merge_data[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (addr_lo[1]) merge_data[31:16] = wdata[15:0];
            else            merge_data[15:0]  = wdata[15:0];
         end
         default: merge_data = wdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : CPU-side initiator for a word-addressed data memory with
//                combinational read and whole-word synchronous write.
//                Sub-word stores are read-modify-write; loads are extracted
//                and extended. Misaligned, reserved-size and out-of-range
//                requests complete with resp_err and never write memory.
//  Ports       : clk, reset (async, active-high)
//                req_valid/req_ready/req_we/req_size/req_signed/req_addr/
//                req_wdata   - request side, accepted only in IDLE
//                resp_valid/resp_rdata/resp_err - one-cycle completion
//                mem_we/mem_a/mem_wd/mem_rd     - memory side
//  Config      : MAU_PERF_CNT_EN adds load_cnt/store_cnt/err_cnt outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int MEM_WORDS = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
`ifdef MAU_PERF_CNT_EN
   ,
   output logic [31:0]       load_cnt,
   output logic [31:0]       store_cnt,
   output logic [31:0]       err_cnt
`endif
);

   localparam logic [ADDR_W-1:0] c_mem_words = ADDR_W'(MEM_WORDS);

   state_e            r_state;
   state_e            w_next;
   logic [ADDR_W-1:0] r_addr;
   size_e             r_size;
   logic              r_we;
   logic              r_signed;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic [31:0]       r_merge;

   size_e             w_size;
   logic              w_req_err;
   logic [31:0]       w_load_data;
   logic [31:0]       w_merge_data;

   assign w_size    = size_e'(req_size);
   assign w_req_err = ~aligned_ok(w_size, req_addr[1:0]) |
                      ({2'b00, req_addr[ADDR_W-1:2]} >= c_mem_words);

   // Shared by LOAD (extract) and RMW_RD (merge); both read the latched word.
   mau_lane_mux u_lane_mux (
      .word       (mem_rd),
      .addr_lo    (r_addr[1:0]),
      .size       (r_size),
      .sgn        (r_signed),
      .wdata      (r_wdata),
      .load_data  (w_load_data),
      .merge_data (w_merge_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr   <= '0;
         r_size   <= SZ_BYTE;
         r_we     <= 1'b0;
         r_signed <= 1'b0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_merge  <= '0;
      end else begin
         if (r_state == IDLE && req_valid) begin
            r_addr   <= req_addr;
            r_size   <= w_size;
            r_we     <= req_we;
            r_signed <= req_signed;
            r_wdata  <= req_wdata;
            // Word stores skip RMW_RD, so the buffer is preloaded here.
            r_merge  <= req_wdata;
         end
         if (r_state == LOAD)   r_rdata <= w_load_data;
         if (r_state == RMW_RD) r_merge <= w_merge_data;
      end
   end

   // Every memory-side output decodes from the state register alone, so an
   // async reset removes mem_we without waiting for a clock edge.
   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      mem_we     = 1'b0;
      mem_wd     = '0;
      mem_a      = {r_addr[ADDR_W-1:2], 2'b00};
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            mem_a     = '0;
            if (req_valid) begin
               if (w_req_err)             w_next = ERR;
               else if (!req_we)          w_next = LOAD;
               else if (w_size == SZ_WORD) w_next = STORE;
               else                       w_next = RMW_RD;
            end
         end
         LOAD:   w_next = RESP;
         RMW_RD: w_next = STORE;
         STORE: begin
            mem_we = 1'b1;
            mem_wd = r_merge;
            w_next = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = r_we ? 32'h0 : r_rdata;
            w_next     = IDLE;
         end
         ERR: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            w_next     = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

`ifdef MAU_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_cnt  <= '0;
         store_cnt <= '0;
         err_cnt   <= '0;
      end else if (r_state == RESP) begin
         if (r_we) store_cnt <= store_cnt + 32'd1;
         else      load_cnt  <= load_cnt + 32'd1;
      end else if (r_state == ERR) begin
         err_cnt <= err_cnt + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Scoreboard bench for mem_access_unit. Holds the data memory
//                the DUT drives plus a separate reference memory updated by an
//                arithmetic model of load/store/error rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   localparam int ADDR_W    = 32;
   localparam int MEM_WORDS = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_a;
   logic [31:0]       mem_wd;
   logic [31:0]       mem_rd;
`ifdef MAU_PERF_CNT_EN
   logic [31:0]       load_cnt;
   logic [31:0]       store_cnt;
   logic [31:0]       err_cnt;
`endif

   mem_access_unit #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
`ifdef MAU_PERF_CNT_EN
      ,
      .load_cnt   (load_cnt),
      .store_cnt  (store_cnt),
      .err_cnt    (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- memory environment and reference state ----------------
   logic [31:0] ram     [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];
   int          mem_idx;

   assign mem_idx = int'(mem_a >> 2);

   always_comb begin
      mem_rd = 32'h0;
      if (mem_idx < MEM_WORDS) mem_rd = ram[mem_idx];
   end

   always @(posedge clk) begin
      if (mem_we && mem_idx < MEM_WORDS) ram[mem_idx] <= mem_wd;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          cyc;
      int          nwe;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   we_obs = 0;
   int   n_load = 0, n_store = 0, n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (plain arithmetic) ----------------
   function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
      int nbytes;
      nbytes = 1 << size;
      return (size == 2'b11) || ((addr % nbytes) != 0) || ((addr >> 2) >= MEM_WORDS);
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                            input logic [31:0] addr);
      longint w, v;
      int     shift, nbits;
      w     = longint'(ref_mem[addr >> 2]);
      shift = int'(addr % 4) * 8;
      nbits = 8 << size;
      v     = (w >> shift) & ((64'd1 << nbits) - 1);
      if (sgn && nbits < 32 && v >= (64'd1 << (nbits - 1))) v = v - (64'd1 << nbits);
      return v[31:0];
   endfunction

   function automatic logic [31:0] ref_store(input logic [1:0] size, input logic [31:0] addr,
                                             input logic [31:0] wdata);
      longint w, mask, d;
      int     shift, nbits;
      w     = longint'(ref_mem[addr >> 2]);
      shift = int'(addr % 4) * 8;
      nbits = 8 << size;
      mask  = ((64'd1 << nbits) - 1) << shift;
      d     = longint'(wdata) << shift;
      w     = (w & ~mask) | (d & mask);
      return w[31:0];
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (mem_we) begin
            we_obs++;
            chk("mem_we_in_range", 32'(mem_idx < MEM_WORDS), 32'd1);
         end
         chk("mem_a_aligned", {30'd0, mem_a[1:0]}, 32'd0);
         if (!mem_we) chk("mem_wd_idle_zero", mem_wd, 32'd0);
         if (resp_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("resp_err",    {31'd0, resp_err}, {31'd0, e.err});
               chk("resp_rdata",  resp_rdata, e.rdata);
               chk("resp_cycle",  32'(cyc), 32'(e.cyc));
               chk("mem_we_count", 32'(we_obs), 32'(e.nwe));
            end
            we_obs = 0;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
      exp_t e;
      int   n;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      e.err = ref_err(size, addr);
      e.nwe = 0;
      e.rdata = 32'h0;
      if (e.err) begin
         e.cyc = cyc + 1;
         n_err++;
      end else if (!we) begin
         e.rdata = ref_load(size, sgn, addr);
         e.cyc = cyc + 2;
         n_load++;
      end else begin
         ref_mem[addr >> 2] = ref_store(size, addr, wdata);
         e.nwe = 1;
         e.cyc = (size == 2'b10) ? cyc + 2 : cyc + 3;
         n_store++;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      // Scramble the request bus; it must be ignored outside IDLE.
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic assert_reset_now(input string tag);
      reset = 1'b1;
      exp_q.delete();
      we_obs  = 0;
      n_load  = 0;
      n_store = 0;
      n_err   = 0;
      #1;
      chk({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
      chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata,          32'd0);
      chk({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
      chk({tag, "_mem_a"},      mem_a,               32'd0);
      chk({tag, "_mem_wd"},     mem_wd,              32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] saved;
      logic [1:0]  sz;
      logic [31:0] ad;

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      for (int i = 0; i < MEM_WORDS; i++) begin
         ram[i]     = $urandom;
         ref_mem[i] = ram[i];
      end
      repeat (2) @(negedge clk);
      assert_reset_now("por");
      @(negedge clk);
      reset = 1'b0;

      // word store then load
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      wait_idle();
      chk("word_store_mem", ram[4], 32'hDEADBEEF);

      // byte store + loads
      do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5);
      do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
      do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
      wait_idle();
      chk("byte_store_mem", ram[4], 32'hDEADA5EF);

      // half store + loads
      do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001);
      do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
      do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
      wait_idle();
      chk("half_store_mem", ram[4], 32'h8001A5EF);

      // error cases
      do_req(1'b0, 2'b01, 1'b0, 32'h13,  32'h0);
      do_req(1'b1, 2'b10, 1'b0, 32'h102, 32'hCAFEF00D);
      do_req(1'b1, 2'b11, 1'b0, 32'h10,  32'h11111111);
      do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      wait_idle();
      chk("err_mem_unchanged", ram[4], 32'h8001A5EF);

      // reset while mem_we is high (STORE of a word store)
      saved = ref_mem[8];
      do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
      assert_reset_now("rst_store");
      ref_mem[8] = saved;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_store_mem", ram[8], saved);

      // reset during RMW_RD of a byte store
      saved = ref_mem[4];
      do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000005A);
      assert_reset_now("rst_rmw");
      ref_mem[4] = saved;
      @(negedge clk);
      chk("rst_rmw_we_low", {31'd0, mem_we}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_rmw_mem", ram[4], 32'h8001A5EF);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      wait_idle();

      // randomized traffic, biased toward legal requests with some errors
      for (int i = 0; i < 300; i++) begin
         sz = 2'($urandom_range(0, 3));
         ad = $urandom_range(0, MEM_WORDS * 4 + 31);
         if ($urandom_range(0, 3) != 0 && sz != 2'b11) ad = ad & ~((32'd1 << sz) - 1);
         do_req(1'($urandom), sz, 1'($urandom), ad, $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle();

      for (int i = 0; i < MEM_WORDS; i++) chk($sformatf("final_mem[%0d]", i), ram[i], ref_mem[i]);

`ifdef MAU_PERF_CNT_EN
      repeat (2) @(negedge clk);
      chk("load_cnt",  load_cnt,  32'(n_load));
      chk("store_cnt", store_cnt, 32'(n_store));
      chk("err_cnt",   err_cnt,   32'(n_err));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
CPU-side initiator for the 32-bit word-addressed data memory. It accepts byte, halfword and word load/store requests from the pipeline. It drives the memory's we/a/wd/rd interface: combinational read, write on posedge clk, whole-word writes only. Sub-word stores are done as read-modify-write, and loads are extracted and extended, so the datapath never handles byte lanes.

Parameters:
ADDR_W, 32, byte-address width of req_addr and mem_a
MEM_WORDS, 64, number of words in data memory; word index >= MEM_WORDS is an access error

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  valid with resp_valid: misaligned, reserved size, or out of range
mem_we  output  1  to memory write enable
mem_a  output  ADDR_W  to memory address, always word-aligned (bits 1:0 = 0)
mem_wd  output  32  to memory write data
mem_rd  input  32  from memory read data, combinational on mem_a

Behaviour:
- Reset (async): state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_we=0; mem_a=0; mem_wd=0. Reset asserted mid-operation drops mem_we immediately. No partial write may ever occur.
- Accept: req_valid && req_ready at a posedge latches addr, size, we, signed and wdata. Inputs are don't-care outside IDLE.
- Lanes are little-endian: byte k = bits 8k+7:8k, selected by addr[1:0]; half selected by addr[1].
- Error check at accept: half with addr[0]=1, word with addr[1:0]!=0, size 11, or addr[ADDR_W-1:2] >= MEM_WORDS. On error go to ERR, never assert mem_we, and leave memory unchanged.
- FSM states: IDLE, LOAD, RMW_RD, STORE, RESP, ERR.
- IDLE -> ERR on error; -> LOAD for a load; -> STORE for a word store; -> RMW_RD for a byte/half store.
- LOAD: drive mem_a; at the posedge capture extract(mem_rd), extended per req_signed, into resp_rdata; -> RESP.
- RMW_RD: drive mem_a; at the posedge capture mem_rd with the target lane(s) replaced by wdata low bits into the merge buffer; -> STORE.
- STORE: mem_we=1 for exactly one cycle; mem_wd is the merge buffer (word store: wdata); -> RESP.
- RESP: resp_valid=1, resp_err=0 for one cycle; -> IDLE.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0 for one cycle; -> IDLE.
- Latency, counted in cycles of resp_valid after the accept edge: load 2nd cycle, word store 2nd, sub-word store 3rd, error 1st.
- There is no response backpressure. The next request can be accepted at the edge ending RESP/ERR, since req_ready is high again in IDLE.
- mem_a holds the latched aligned address from accept until return to IDLE; mem_wd is 0 except in STORE.

Optional Feature:
MAU_PERF_CNT_EN: when defined, adds output ports load_cnt[31:0], store_cnt[31:0] and err_cnt[31:0]. Each counter increments by 1 at the edge leaving RESP (load/store) or ERR (err), wraps modulo 2^32, and is cleared by reset. When not defined, these ports and their counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package mau_pkg holds:
  - size_e (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11)
  - state_e (the six FSM states)
  - function aligned_ok(size, addr[1:0])
- One combinational sub-module, mau_lane_mux, handles both directions: extract/extend for loads and merge for stores, from inputs word, addr[1:0], size, signed and wdata.

Test Plan:
1. Assert reset mid-run -> req_ready=1, resp_valid=0, mem_we=0, mem_a=0 with no clock edge needed; release -> idle.
2. Word store 0xDEADBEEF to 0x10, then word load from 0x10 -> store resp on 2nd cycle after accept with one mem_we pulse; load returns resp_rdata=0xDEADBEEF on 2nd cycle.
3. Byte store 0x000000A5 to 0x11 over 0xDEADBEEF -> mem word 0xDEADA5EF, resp on 3rd cycle; signed byte load 0x11 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
4. Half store 0x00008001 to 0x12 -> word 0x8001A5EF; signed half load 0x12 -> 0xFFFF8001; unsigned -> 0x00008001.
5. Half load from 0x13, word store to 0x102, size 11, and word load from 0x100 -> each gives resp_err=1 on 1st cycle with resp_rdata=0, mem_we never high, memory unchanged.
6. Reset asserted during RMW_RD of a byte store to 0x10 -> mem_we stays 0 and the word is unchanged; after release a new word load from 0x10 returns the original value.
